// File: rtl/ascon_perm_sched.sv
// ---------------------------------------------------------------------------
// ascon_perm_sched
//
// Bus-mapped sequencer for the Ascon 320-bit permutation. It owns the
// 320-bit state, loads it through ten 32-bit word registers, and runs an
// external single-round combinational core once per clock. On each round it
// supplies the matching round-constant index. When the run ends, the result
// stays in the word registers and the done/err status is available to
// firmware.
//
// Register map (bus_addr):
//   0..9  state word k = state[319-32k : 288-32k]; word 0 holds the MSBs.
//         Byte-writable. Reads return the live (possibly intermediate) state.
//   10    CTRL (write only): bit0 start, bits7:4 rounds (0 -> DEF_ROUNDS),
//         bit8 clear done/err (and irq). A clear is applied before a start.
//   11    STATUS (read): bit0 busy, bit1 done, bit2 err, bits7:4 latched rounds.
//   12-15 unmapped: reads return 0, writes are ignored.
//
// Ports:
//   clk, resetn             clock, asynchronous active-low reset
//   bus_we[3:0]             byte write strobes for the addressed register
//   bus_re                  one-cycle read strobe
//   bus_addr[3:0]           register index
//   bus_wdata[31:0]         write data
//   bus_rdata[31:0]         registered read data, valid the cycle after bus_re
//   bus_wait                high in the cycle a read is requested
//   rnd_in[319:0]           state presented to the round core
//   rnd_idx[3:0]            round-constant index for the current round
//   rnd_out[319:0]          round core result (combinational from rnd_in/idx)
//   busy                    permutation in progress
//   done                    result valid; sticky until cleared or restarted
//   irq                     completion interrupt
//
// Optional feature, selected by the macro ASCON_PERM_SCHED_IRQ_EN:
//   defined   - irq rises together with done and stays high until a CTRL clear
//               write or a STATUS read. A STATUS read in the cycle done rises
//               does not clear it.
//   undefined - irq is tied low and STATUS reads have no side effects.
// ---------------------------------------------------------------------------
module ascon_perm_sched #(
  parameter int MAX_ROUNDS = 12,
  parameter int DEF_ROUNDS = 12
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [3:0]   bus_we,
  input  logic         bus_re,
  input  logic [3:0]   bus_addr,
  input  logic [31:0]  bus_wdata,
  output logic [31:0]  bus_rdata,
  output logic         bus_wait,
  output logic [319:0] rnd_in,
  output logic [3:0]   rnd_idx,
  input  logic [319:0] rnd_out,
  output logic         busy,
  output logic         done,
  output logic         irq
);

  localparam logic [3:0] ADDR_CTRL   = 4'd10;
  localparam logic [3:0] ADDR_STATUS = 4'd11;
  localparam logic [3:0] MAX_R       = 4'(MAX_ROUNDS);
  localparam logic [3:0] DEF_R       = 4'(DEF_ROUNDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } fsm_t;

  fsm_t             fsm_q;
  logic [9:0][31:0] st_q;     // st_q[9] is bus word 0 (the MSBs)
  logic [3:0]       cnt_q;
  logic [3:0]       r_lat_q;
  logic             err_q;

  logic        wr_any;
  logic        wr_word;
  logic        wr_ctrl;
  logic [3:0]  widx;
  logic        ctrl_start;
  logic        ctrl_clear;
  logic [3:0]  req_r;
  logic [3:0]  eff_r;
  logic        r_bad;
  logic        start_ok;
  logic        last_round;
  logic [31:0] rd_val;

  assign rnd_in = st_q;

  // Bus decode. CTRL fields are honoured only when their byte lane is strobed.
  assign wr_any     = |bus_we;
  assign wr_word    = wr_any && (bus_addr < 4'd10);
  assign wr_ctrl    = wr_any && (bus_addr == ADDR_CTRL);
  assign widx       = 4'd9 - bus_addr;
  assign ctrl_start = bus_we[0] & bus_wdata[0];
  assign ctrl_clear = bus_we[1] & bus_wdata[8];
  assign req_r      = bus_wdata[7:4];
  assign eff_r      = (req_r == 4'd0) ? DEF_R : req_r;
  assign r_bad      = (eff_r > MAX_R);
  assign start_ok   = wr_ctrl && !busy && ctrl_start && !r_bad;
  assign last_round = (fsm_q == S_RUN) && (cnt_q == 4'd1);

  // The read response is registered, so the bus is held for exactly the
  // request cycle.
  assign bus_wait = bus_re;

  always_comb begin
    rd_val = '0;
    if (bus_addr < 4'd10) begin
      rd_val = st_q[widx];
    end else if (bus_addr == ADDR_STATUS) begin
      rd_val = {24'd0, r_lat_q, 1'b0, err_q, done, busy};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_rdata <= '0;
    end else if (bus_re) begin
      bus_rdata <= rd_val;
    end
  end

  // Sequencer and register file. busy mirrors the RUN state and is kept as
  // its own register so that it is a clean registered output.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fsm_q   <= S_IDLE;
      st_q    <= '0;
      cnt_q   <= '0;
      rnd_idx <= '0;
      r_lat_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (busy) begin
        // The running permutation is never disturbed; the attempt is flagged.
        if (wr_word || wr_ctrl) begin
          err_q <= 1'b1;
        end
      end else begin
        if (wr_word) begin
          for (int b = 0; b < 4; b++) begin
            if (bus_we[b]) begin
              st_q[widx][8*b +: 8] <= bus_wdata[8*b +: 8];
            end
          end
        end
        if (wr_ctrl && ctrl_clear) begin
          done  <= 1'b0;
          err_q <= 1'b0;
        end
        // Written after the clear so that an illegal start also sets err
        // when the clear bit is set in the same write.
        if (wr_ctrl && ctrl_start && r_bad) begin
          err_q <= 1'b1;
        end
      end

      unique case (fsm_q)
        S_IDLE, S_FIN: begin
          fsm_q <= S_IDLE;
          if (start_ok) begin
            fsm_q   <= S_RUN;
            busy    <= 1'b1;
            done    <= 1'b0;
            cnt_q   <= eff_r;
            rnd_idx <= MAX_R - eff_r;
            r_lat_q <= eff_r;
          end
        end
        S_RUN: begin
          st_q  <= rnd_out;
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            fsm_q <= S_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            // The index is held on the last round, so it never passes
            // MAX_ROUNDS-1.
            rnd_idx <= rnd_idx + 4'd1;
          end
        end
        default: begin
          fsm_q <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ASCON_PERM_SCHED_IRQ_EN
  logic irq_q;

  // Setting has priority. A STATUS read in the FIN cycle, when done has just
  // risen, leaves the interrupt pending.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      irq_q <= 1'b0;
    end else if (last_round) begin
      irq_q <= 1'b1;
    end else if (wr_ctrl && !busy && ctrl_clear) begin
      irq_q <= 1'b0;
    end else if (bus_re && (bus_addr == ADDR_STATUS) && (fsm_q != S_FIN)) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`else
  logic unused_last_round;

  assign unused_last_round = last_round;
  assign irq = 1'b0;
`endif

  logic unused_wdata;

  assign unused_wdata = ^{bus_wdata[31:9], bus_wdata[3:1]};

endmodule

// File: doc/ascon_perm_sched.md
Name: ascon_perm_sched

Overview:
- Bus-mapped sequencer for the Ascon 320-bit permutation, attached to the picosoc peripheral bus.
- Owns the 320-bit state register and accepts ten 32-bit word writes plus a start command carrying a round count.
- Iterates an external single-round combinational core once per clock, applying the correct round-constant index each cycle, then exposes the result and busy/done status to firmware.
- Replaces free-running start/ready glue with an explicit, resettable state machine.

Parameters:
- MAX_ROUNDS, 12, upper legal round count; round index runs MAX_ROUNDS-r .. MAX_ROUNDS-1.
- DEF_ROUNDS, 12, round count used when CTRL.rounds field is written as 0.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- bus_we  in  4  byte write strobes for the addressed register
- bus_re  in  1  read strobe, one-cycle pulse
- bus_addr  in  4  register index: 0-9 state words, 10 CTRL, 11 STATUS
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, registered
- bus_wait  out  1  high while the read response is pending
- rnd_in  out  320  state presented to the round core (the state register)
- rnd_idx  out  4  round-constant index for the current round
- rnd_out  in  320  round core result, combinational from rnd_in/rnd_idx
- busy  out  1  permutation in progress
- done  out  1  result valid, sticky until cleared
- irq  out  1  completion interrupt (see Optional Feature)

Behaviour:
- Reset (async, resetn=0): state register=0, FSM=IDLE, rnd_idx=0, round counter=0, bus_rdata=0, bus_wait=0, busy=0, done=0, err=0, irq=0.
- State words:
  - Word k (k=0..9) maps to state[319-32k : 288-32k]; word 0 holds the most significant bits.
  - Byte writes are honoured per bus_we bit.
- CTRL (addr 10) write:
  - bit0 = start; bits7:4 = rounds r; bit8 = clear done/err.
  - r=0 is replaced by DEF_ROUNDS. r>MAX_ROUNDS sets err and does not start.
- STATUS (addr 11) read: bit0 busy, bit1 done, bit2 err, bits7:4 latched r. Other bits read 0.
- FSM:
  - IDLE -> RUN on a valid start write. Load counter=r and rnd_idx=MAX_ROUNDS-r. Clear done.
  - RUN, each cycle: state <= rnd_out; rnd_idx <= rnd_idx+1; counter <= counter-1. When counter==1, go to FIN.
  - FIN: set done for one FSM cycle, then return to IDLE. done stays high until cleared or a new start.
- Latency: start written in cycle T gives busy=1 in cycles T+1..T+r. done=1 from T+r+1. rnd_idx advances once per cycle.
- Reads:
  - bus_re in cycle T sets bus_wait=1 in T; bus_rdata is valid and bus_wait=0 in T+1.
  - Reads of state words while busy return the intermediate state and do not stall.
- Boundary conditions:
  - State-word or CTRL writes while busy: ignored, and err is set. No effect on the running permutation.
  - Start and clear in the same write: clear applies first, then start.
  - Unmapped addresses 12-15: reads return 0, writes are ignored.
  - Reset mid-RUN aborts immediately to reset values; the partial state is discarded.
  - rnd_idx never exceeds MAX_ROUNDS-1.

Optional Feature:
- Macro ASCON_PERM_SCHED_IRQ_EN.
- Defined: irq rises with done (cycle T+r+1) and stays high until a CTRL clear write or a STATUS read. A STATUS read in the same cycle done rises leaves irq set.
- Undefined: irq is tied 0, and STATUS reads have no side effects.

Test Plan:
- Reset mid-run: assert resetn=0 during RUN with nonzero state and r=12 -> all outputs, including state words, read 0; STATUS=0x0.
- Full-round check: write words 0-9 with 0x00000000..0x00000009, then CTRL=0xC1 -> busy exactly 12 cycles; rnd_idx sequence 0,1,..,11; done=1; words 0-9 match the reference-model 12-round output.
- Reduced-round check: same state with CTRL=0x61 -> rnd_idx 6..11; busy 6 cycles; result matches the reference 6-round output. CTRL=0x01 behaves identically to 0xC1.
- Illegal round count: CTRL=0xD1 (r=13) -> no start, busy=0, STATUS=0x4. CTRL=0x100 -> STATUS=0x0.
- Write while busy: write word 3 = 0xDEADBEEF while busy -> err=1; final result identical to the undisturbed run.
- Interrupt (with ASCON_PERM_SCHED_IRQ_EN): irq high at T+13 after an r=12 start; a STATUS read drops irq the next cycle. Without the macro, irq=0 throughout.
